// File: rtl/fetch_align_buffer_pkg.sv
// Shared types and helpers for the fetch align buffer and its halfword FIFO.
package fetch_align_buffer_pkg;

   typedef logic [15:0] halfword_t;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // A halfword starts a compressed instruction unless its low two bits are 11.
   function automatic logic is_rvc(input halfword_t hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// Bus bundle between program memory, redirect source and the decompressor.
interface fetch_align_buffer_if;
   import fetch_align_buffer_pkg::*;

   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               mem_req_valid;
   logic [31:0]        mem_req_addr;
   logic [31:0]        mem_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [31:0]        out_pc;
   logic               out_is_compressed;

   modport master (
      input  redirect_valid, redirect_pc, mem_rdata, out_ready,
      output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, out_is_compressed
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_rdata, out_ready,
      input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, out_is_compressed
   );

endinterface

// File: rtl/fetch_align_buffer_halfword_fifo.sv
// Circular halfword FIFO: pushes and pops 0..2 halfwords per cycle and
// exposes the two oldest entries so the parent can assemble an instruction.
module fetch_align_buffer_halfword_fifo
   import fetch_align_buffer_pkg::*;
#(
   parameter  int DEPTH_HW = 4,
   localparam int PTR_W    = $clog2(DEPTH_HW),
   localparam int CNT_W    = $clog2(DEPTH_HW + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [1:0]       push_n,
   input  halfword_t        push_hw0,
   input  halfword_t        push_hw1,
   input  logic [1:0]       pop_n,
   output halfword_t        head0,
   output halfword_t        head1,
   output logic [CNT_W-1:0] count
);

   localparam logic [PTR_W:0] DEPTH_P = (PTR_W + 1)'(DEPTH_HW);

   halfword_t        mem [DEPTH_HW];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointer advance modulo DEPTH_HW, so non power-of-two depths wrap correctly.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + (PTR_W + 1)'(n);
      if (s >= DEPTH_P) s = s - DEPTH_P;
      return s[PTR_W-1:0];
   endfunction

   // Storage writes; data is not reset, only the pointers and count are.
   always_ff @(posedge clk) begin
      if (!clr) begin
         if (push_n != 2'd0) mem[wr_ptr] <= push_hw0;
         if (push_n == 2'd2) mem[ptr_add(wr_ptr, 2'd1)] <= push_hw1;
      end
   end

   // Pointer and occupancy bookkeeping; count moves by the net push minus pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= ptr_add(rd_ptr, pop_n);
         wr_ptr <= ptr_add(wr_ptr, push_n);
         count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
      end
   end

   // The two oldest halfwords, valid according to count.
   always_comb begin
      head0 = mem[rd_ptr];
      head1 = mem[ptr_add(rd_ptr, 2'd1)];
   end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch align buffer: issues word reads, buffers halfwords and hands the
// decompressor one complete 16- or 32-bit instruction per handshake.
module fetch_align_buffer
   import fetch_align_buffer_pkg::*;
#(
   parameter int          DEPTH_HW = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input logic                  clk,
   input logic                  reset,
   fetch_align_buffer_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH_HW + 1);

   logic [31:0]      fetch_addr;
   logic [31:0]      head_pc;
   logic             skip_low;
   logic             inflight;
   logic             epoch;
   logic             resp_epoch;

   halfword_t        head0;
   halfword_t        head1;
   logic [CNT_W-1:0] count;
   logic [1:0]       push_n;
   logic [1:0]       pop_n;
   halfword_t        push_hw0;
   logic             head_rvc;
   logic             resp_ok;
   logic             fire;
   logic [CNT_W+1:0] need;

   fetch_align_buffer_halfword_fifo #(.DEPTH_HW(DEPTH_HW)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clr      (bus.redirect_valid),
      .push_n   (push_n),
      .push_hw0 (push_hw0),
      .push_hw1 (bus.mem_rdata[31:16]),
      .pop_n    (pop_n),
      .head0    (head0),
      .head1    (head1),
      .count    (count)
   );

   // Request, response acceptance and output assembly; a redirect suppresses all of them.
   always_comb begin
      head_rvc = is_rvc(head0);
      // Reserve two slots per outstanding word so a response always has room.
      need     = (CNT_W + 2)'(count) + (inflight ? (CNT_W + 2)'(4) : (CNT_W + 2)'(2));
      bus.mem_req_valid = !reset && !bus.redirect_valid && (need <= (CNT_W + 2)'(DEPTH_HW));
      bus.mem_req_addr  = fetch_addr;

      // Responses from before the last redirect carry a stale epoch and are dropped.
      resp_ok  = inflight && (resp_epoch == epoch) && !bus.redirect_valid;
      push_n   = resp_ok ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
      push_hw0 = skip_low ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

      bus.out_valid         = !bus.redirect_valid && (count != '0) &&
                              (head_rvc || count >= CNT_W'(2));
      bus.out_is_compressed = (count != '0) && head_rvc;
      bus.out_pc            = head_pc;
      bus.out_instr         = '0;
      if (count != '0) bus.out_instr = head_rvc ? {16'h0000, head0} : {head1, head0};

      fire  = bus.out_valid && bus.out_ready;
      pop_n = fire ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
   end

   // Fetch address, head PC, epoch and in-flight tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_addr <= {RESET_PC[31:2], 2'b00};
         head_pc    <= RESET_PC;
         skip_low   <= 1'b0;
         inflight   <= 1'b0;
         epoch      <= 1'b0;
         resp_epoch <= 1'b0;
      end else if (bus.redirect_valid) begin
         fetch_addr <= bus.redirect_pc & ~32'h3;
         head_pc    <= bus.redirect_pc & ~32'h1;
         skip_low   <= bus.redirect_pc[1];
         inflight   <= 1'b0;
         epoch      <= ~epoch;
      end else begin
         inflight <= bus.mem_req_valid;
         if (bus.mem_req_valid) begin
            fetch_addr <= fetch_addr + 32'd4;
            resp_epoch <= epoch;
         end
         if (resp_ok) skip_low <= 1'b0;
         if (fire) head_pc <= head_pc + (head_rvc ? 32'd2 : 32'd4);
      end
   end

endmodule
